mux_4_1_rr_arbiter: RTL

//   Shares one W-bit output channel among four valid/ready requesters using

---
 rtl/mux_4_1_rr_arbiter.sv | 86 ++++++++
 1 files changed

// File: rtl/mux_4_1_rr_arbiter.sv
// Four-requester round-robin arbiter driving a 4:1 data mux into a single registered
// valid/ready output stage that can drain and reload in the same cycle.
module mux_4_1_rr_arbiter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   in_vld,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [3:0]   in_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_src,
    input  logic         out_rdy
);

    logic         out_vld_q;
    logic [W-1:0] out_data_q;
    logic [1:0]   out_src_q;
    logic [1:0]   last_q;

    logic         can_load;
    logic         load;
    logic [1:0]   winner;
    logic         found;
    logic [1:0]   idx;
    logic [W-1:0] sel_data;

    // Search starts just after the last grant, so the previous winner is tried last.
    always_comb begin
        winner = last_q;
        found  = 1'b0;
        idx    = last_q;
        for (int k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && in_vld[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        unique case (winner)
            2'd0:    sel_data = d0;
            2'd1:    sel_data = d1;
            2'd2:    sel_data = d2;
            default: sel_data = d3;
        endcase
    end

    assign can_load = !out_vld_q || out_rdy;
    assign load     = can_load && (|in_vld) && !rst;

    always_comb begin
        in_rdy = 4'b0000;
        if (load) begin
            in_rdy = 4'b0001 << winner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_src_q  <= 2'd0;
            last_q     <= 2'd3;
        end else if (load) begin
            out_vld_q  <= 1'b1;
            out_data_q <= sel_data;
            out_src_q  <= winner;
            last_q     <= winner;
        end else if (can_load) begin
            // Drained with nothing to replace it; data/src keep their last value.
            out_vld_q <= 1'b0;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign out_src  = out_src_q;

endmodule
